// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control unit <-> datapath signal bundle
interface control_unit_if;
    logic [5:0] Operation;
    logic [5:0] Funct;
    logic       ALU_zero;
    logic       pc_reset;
    logic       pc_load;
    logic       instReg_reset;
    logic       instReg_load;
    logic       a_reset;
    logic       a_load;
    logic       b_reset;
    logic       b_load;
    logic       ALUout_reset;
    logic       ALUout_load;
    logic       mdr_load;
    logic       mem_write;
    logic       iord;
    logic       ALU_srcA;
    logic [1:0] ALU_srcB;
    logic [2:0] ALU_select;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       error;

    // controller side: reads instruction fields, drives every control line
    modport master (
        input  Operation, Funct, ALU_zero,
        output pc_reset, pc_load, instReg_reset, instReg_load,
               a_reset, a_load, b_reset, b_load, ALUout_reset, ALUout_load,
               mdr_load, mem_write, iord, ALU_srcA, ALU_srcB, ALU_select,
               pc_source, reg_write, reg_dst, mem_to_reg, error
    );

    // datapath side
    modport slave (
        output Operation, Funct, ALU_zero,
        input  pc_reset, pc_load, instReg_reset, instReg_load,
               a_reset, a_load, b_reset, b_load, ALUout_reset, ALUout_load,
               mdr_load, mem_write, iord, ALU_srcA, ALU_srcB, ALU_select,
               pc_source, reg_write, reg_dst, mem_to_reg, error
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle Moore FSM for the MIPS-subset datapath
module control_unit (
    input  logic          Clk,
    input  logic          reset,
    control_unit_if.master bus
);

    // The lw/sw and beq/bne split is carried in the state itself so that
    // Operation only needs to be looked at while decoding.
    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_FETCH_WAIT, S_DECODE,
        S_R_EXEC, S_R_WB, S_ADDI_EXEC, S_ADDI_WB,
        S_ADDR_LW, S_ADDR_SW, S_LW_READ, S_LW_WAIT, S_LW_WB, S_SW_WRITE,
        S_BEQ, S_BNE, S_JUMP, S_HALT
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b110;

    state_t state;
    state_t next_state;
    logic [2:0] r_alu_sel;

    // R-type function field to ALU operation; 000 marks an unsupported funct
    always_comb begin
        case (bus.Funct)
            6'h20:   r_alu_sel = ALU_ADD;
            6'h22:   r_alu_sel = ALU_SUB;
            6'h24:   r_alu_sel = ALU_AND;
            6'h26:   r_alu_sel = ALU_XOR;
            default: r_alu_sel = 3'b000;
        endcase
    end

    // state register; reset wins from any state
    always_ff @(posedge Clk) begin
        if (reset) state <= S_RESET;
        else       state <= next_state;
    end

    // next-state decode
    always_comb begin
        next_state = S_HALT;
        case (state)
            S_RESET:      next_state = S_FETCH;
            S_FETCH:      next_state = S_FETCH_WAIT;
            S_FETCH_WAIT: next_state = S_DECODE;
            S_DECODE: begin
                case (bus.Operation)
                    6'h00:   next_state = S_R_EXEC;
                    6'h08:   next_state = S_ADDI_EXEC;
                    6'h23:   next_state = S_ADDR_LW;
                    6'h2B:   next_state = S_ADDR_SW;
                    6'h04:   next_state = S_BEQ;
                    6'h05:   next_state = S_BNE;
                    6'h02:   next_state = S_JUMP;
                    default: next_state = S_HALT;
                endcase
            end
            S_R_EXEC:     next_state = (r_alu_sel == 3'b000) ? S_HALT : S_R_WB;
            S_R_WB:       next_state = S_FETCH;
            S_ADDI_EXEC:  next_state = S_ADDI_WB;
            S_ADDI_WB:    next_state = S_FETCH;
            S_ADDR_LW:    next_state = S_LW_READ;
            S_ADDR_SW:    next_state = S_SW_WRITE;
            S_LW_READ:    next_state = S_LW_WAIT;
            S_LW_WAIT:    next_state = S_LW_WB;
            S_LW_WB:      next_state = S_FETCH;
            S_SW_WRITE:   next_state = S_FETCH;
            S_BEQ:        next_state = S_FETCH;
            S_BNE:        next_state = S_FETCH;
            S_JUMP:       next_state = S_FETCH;
            S_HALT:       next_state = S_HALT;
            default:      next_state = S_HALT;
        endcase
    end

    // control outputs from the current state (branch pc_load also uses ALU_zero)
    always_comb begin
        bus.pc_reset      = 1'b0;
        bus.pc_load       = 1'b0;
        bus.instReg_reset = 1'b0;
        bus.instReg_load  = 1'b0;
        bus.a_reset       = 1'b0;
        bus.a_load        = 1'b0;
        bus.b_reset       = 1'b0;
        bus.b_load        = 1'b0;
        bus.ALUout_reset  = 1'b0;
        bus.ALUout_load   = 1'b0;
        bus.mdr_load      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.ALU_srcA      = 1'b0;
        bus.ALU_srcB      = 2'b00;
        bus.ALU_select    = 3'b000;
        bus.pc_source     = 2'b00;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.error         = 1'b0;
        case (state)
            S_RESET: begin
                bus.pc_reset      = 1'b1;
                bus.instReg_reset = 1'b1;
                bus.a_reset       = 1'b1;
                bus.b_reset       = 1'b1;
                bus.ALUout_reset  = 1'b1;
            end
            S_FETCH_WAIT: begin
                bus.instReg_load = 1'b1;
                bus.ALU_srcB     = 2'b01;
                bus.ALU_select   = ALU_ADD;
                bus.pc_load      = 1'b1;
            end
            S_DECODE: begin
                bus.a_load      = 1'b1;
                bus.b_load      = 1'b1;
                bus.ALUout_load = 1'b1;
                bus.ALU_srcB    = 2'b11;
                bus.ALU_select  = ALU_ADD;
            end
            S_R_EXEC: begin
                bus.ALU_srcA    = 1'b1;
                bus.ALUout_load = 1'b1;
                bus.ALU_select  = r_alu_sel;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_ADDI_EXEC, S_ADDR_LW, S_ADDR_SW: begin
                bus.ALU_srcA    = 1'b1;
                bus.ALU_srcB    = 2'b10;
                bus.ALU_select  = ALU_ADD;
                bus.ALUout_load = 1'b1;
            end
            S_ADDI_WB: bus.reg_write = 1'b1;
            S_LW_READ: bus.iord = 1'b1;
            S_LW_WAIT: begin
                bus.iord     = 1'b1;
                bus.mdr_load = 1'b1;
            end
            S_LW_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_SW_WRITE: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_BEQ, S_BNE: begin
                bus.ALU_srcA   = 1'b1;
                bus.ALU_select = ALU_SUB;
                bus.pc_source  = 2'b01;
                bus.pc_load    = (state == S_BEQ) ? bus.ALU_zero : ~bus.ALU_zero;
            end
            S_JUMP: begin
                bus.pc_source = 2'b10;
                bus.pc_load   = 1'b1;
            end
            S_HALT: bus.error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    control_unit_if bus ();

    control_unit dut (.Clk(Clk), .reset(reset), .bus(bus));

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       pc_reset, pc_load, ir_reset, ir_load;
        logic       a_reset, a_load, b_reset, b_load;
        logic       ao_reset, ao_load, mdr_load, mem_write;
        logic       iord, src_a;
        logic [1:0] src_b;
        logic [2:0] sel;
        logic [1:0] pc_src;
        logic       reg_write, reg_dst, mem_to_reg, error;
    } cw_t;

    cw_t obs_q[$];

    function automatic cw_t observe();
        cw_t c;
        c.pc_reset   = bus.pc_reset;     c.pc_load   = bus.pc_load;
        c.ir_reset   = bus.instReg_reset; c.ir_load  = bus.instReg_load;
        c.a_reset    = bus.a_reset;      c.a_load    = bus.a_load;
        c.b_reset    = bus.b_reset;      c.b_load    = bus.b_load;
        c.ao_reset   = bus.ALUout_reset; c.ao_load   = bus.ALUout_load;
        c.mdr_load   = bus.mdr_load;     c.mem_write = bus.mem_write;
        c.iord       = bus.iord;         c.src_a     = bus.ALU_srcA;
        c.src_b      = bus.ALU_srcB;     c.sel       = bus.ALU_select;
        c.pc_src     = bus.pc_source;    c.reg_write = bus.reg_write;
        c.reg_dst    = bus.reg_dst;      c.mem_to_reg = bus.mem_to_reg;
        c.error      = bus.error;
        return c;
    endfunction

    function automatic cw_t reset_word();
        cw_t c = '0;
        c.pc_reset = 1; c.ir_reset = 1; c.a_reset = 1; c.b_reset = 1; c.ao_reset = 1;
        return c;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h20: return 3'b001;
            6'h22: return 3'b010;
            6'h24: return 3'b011;
            6'h26: return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int instr_len(input logic [5:0] op);
        case (op)
            6'h00, 6'h08, 6'h2B: return 5;
            6'h23:               return 7;
            6'h04, 6'h05, 6'h02: return 4;
            default:             return 0;
        endcase
    endfunction

    // expected control word in cycle cyc (1 = FETCH) of one instruction
    function automatic cw_t model(input logic [5:0] op, input logic [5:0] funct,
                                  input logic zero, input int cyc);
        cw_t c = '0;
        if (cyc == 1) begin
        end else if (cyc == 2) begin
            c.ir_load = 1; c.src_b = 2'b01; c.sel = 3'b001; c.pc_load = 1;
        end else if (cyc == 3) begin
            c.a_load = 1; c.b_load = 1; c.ao_load = 1; c.src_b = 2'b11; c.sel = 3'b001;
        end else begin
            case (op)
                6'h00: begin
                    if (cyc == 4) begin
                        c.src_a = 1; c.ao_load = 1; c.sel = funct_alu(funct);
                    end else if (funct_alu(funct) == 3'b000) c.error = 1;
                    else if (cyc == 5) begin c.reg_write = 1; c.reg_dst = 1; end
                end
                6'h08, 6'h23, 6'h2B: begin
                    if (cyc == 4) begin
                        c.src_a = 1; c.src_b = 2'b10; c.sel = 3'b001; c.ao_load = 1;
                    end else if (op == 6'h08) c.reg_write = 1;
                    else if (op == 6'h2B) begin c.iord = 1; c.mem_write = 1; end
                    else if (cyc == 5) c.iord = 1;
                    else if (cyc == 6) begin c.iord = 1; c.mdr_load = 1; end
                    else begin c.reg_write = 1; c.mem_to_reg = 1; end
                end
                6'h04, 6'h05: begin
                    c.src_a = 1; c.sel = 3'b010; c.pc_src = 2'b01;
                    c.pc_load = (op == 6'h04) ? zero : !zero;
                end
                6'h02: begin c.pc_src = 2'b10; c.pc_load = 1; end
                default: c.error = 1;
            endcase
        end
        return c;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    // run n cycles of one instruction; inputs hold only where they are sampled
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                             input logic zero, input int n);
        obs_q.delete();
        for (int c = 1; c <= n; c++) begin
            step();
            if (c == 3 || c == 4) begin
                bus.Operation = op;
                bus.Funct = funct;
            end else begin
                bus.Operation = 6'($urandom);
                bus.Funct = 6'($urandom);
            end
            bus.ALU_zero = (c == 4) ? zero : 1'($urandom);
            @(negedge Clk);
            obs_q.push_back(observe());
        end
    endtask

    task automatic test_reset();
        reset = 1;
        bus.Operation = 0; bus.Funct = 0; bus.ALU_zero = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge Clk);
            checks++;
            if (observe() !== reset_word()) begin
                errors++;
                $display("FAIL reset cyc%0d got %h exp %h", i, observe(), reset_word());
            end
        end
        reset = 0;
    endtask

    task automatic test_rtype();
        logic [5:0] fl [4] = '{6'h20, 6'h22, 6'h24, 6'h26};
        for (int k = 0; k < 4; k++) begin
            run_instr(6'h00, fl[k], 1'b0, 5);
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_q[i] !== model(6'h00, fl[k], 1'b0, i + 1)) begin
                    errors++;
                    $display("FAIL rtype f%h c%0d got %h exp %h", fl[k], i + 1, obs_q[i],
                             model(6'h00, fl[k], 1'b0, i + 1));
                end
            end
        end
    endtask

    task automatic test_lw();
        int mw = 0;
        run_instr(6'h23, 6'h00, 1'b0, 7);
        for (int i = 0; i < 7; i++) begin
            mw += int'(obs_q[i].mem_write);
            checks++;
            if (obs_q[i] !== model(6'h23, 6'h00, 1'b0, i + 1)) begin
                errors++;
                $display("FAIL lw c%0d got %h exp %h", i + 1, obs_q[i], model(6'h23, 6'h00, 1'b0, i + 1));
            end
        end
        checks++;
        if (mw !== 0) begin
            errors++;
            $display("FAIL lw_no_write got %0d exp 0", mw);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2] = '{6'h04, 6'h05};
        for (int k = 0; k < 2; k++) begin
            for (int z = 1; z >= 0; z--) begin
                run_instr(ops[k], 6'h00, 1'(z), 4);
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (obs_q[i] !== model(ops[k], 6'h00, 1'(z), i + 1)) begin
                        errors++;
                        $display("FAIL branch op%h z%0d c%0d got %h exp %h", ops[k], z, i + 1,
                                 obs_q[i], model(ops[k], 6'h00, 1'(z), i + 1));
                    end
                end
            end
        end
    endtask

    task automatic test_addi_sw_jump();
        logic [5:0] ops [3] = '{6'h08, 6'h2B, 6'h02};
        for (int k = 0; k < 3; k++) begin
            run_instr(ops[k], 6'h00, 1'b0, instr_len(ops[k]));
            for (int i = 0; i < instr_len(ops[k]); i++) begin
                checks++;
                if (obs_q[i] !== model(ops[k], 6'h00, 1'b0, i + 1)) begin
                    errors++;
                    $display("FAIL misc op%h c%0d got %h exp %h", ops[k], i + 1, obs_q[i],
                             model(ops[k], 6'h00, 1'b0, i + 1));
                end
            end
        end
    endtask

    task automatic test_bad_funct();
        int rw = 0;
        run_instr(6'h00, 6'h08, 1'b0, 12);
        for (int i = 0; i < 12; i++) begin
            rw += int'(obs_q[i].reg_write);
            checks++;
            if (obs_q[i] !== model(6'h00, 6'h08, 1'b0, i + 1)) begin
                errors++;
                $display("FAIL bad_funct c%0d got %h exp %h", i + 1, obs_q[i], model(6'h00, 6'h08, 1'b0, i + 1));
            end
        end
        checks++;
        if (rw !== 0) begin
            errors++;
            $display("FAIL bad_funct_no_wb got %0d exp 0", rw);
        end
        do_reset();
    endtask

    task automatic test_halt();
        run_instr(6'h3F, 6'h00, 1'b0, 23);
        for (int i = 0; i < 23; i++) begin
            checks++;
            if (obs_q[i] !== model(6'h3F, 6'h00, 1'b0, i + 1)) begin
                errors++;
                $display("FAIL halt c%0d got %h exp %h", i + 1, obs_q[i], model(6'h3F, 6'h00, 1'b0, i + 1));
            end
        end
        reset = 1;
        step();
        @(negedge Clk);
        checks++;
        if (observe() !== reset_word()) begin
            errors++;
            $display("FAIL halt_reset got %h exp %h", observe(), reset_word());
        end
        reset = 0;
    endtask

    task automatic test_sw_reset();
        run_instr(6'h2B, 6'h00, 1'b0, 5);
        checks++;
        if (obs_q[4] !== model(6'h2B, 6'h00, 1'b0, 5)) begin
            errors++;
            $display("FAIL sw_write got %h exp %h", obs_q[4], model(6'h2B, 6'h00, 1'b0, 5));
        end
        reset = 1;
        step();
        @(negedge Clk);
        checks++;
        if (observe() !== reset_word()) begin
            errors++;
            $display("FAIL sw_abort got %h exp %h", observe(), reset_word());
        end
        reset = 0;
        step();
        @(negedge Clk);
        checks++;
        if (observe() !== model(6'h2B, 6'h00, 1'b0, 1)) begin
            errors++;
            $display("FAIL sw_refetch got %h exp %h", observe(), model(6'h2B, 6'h00, 1'b0, 1));
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        logic [5:0] fns [4] = '{6'h20, 6'h22, 6'h24, 6'h26};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op = ops[$urandom_range(0, 6)];
            logic [5:0] fn = fns[$urandom_range(0, 3)];
            logic       z  = 1'($urandom);
            run_instr(op, fn, z, instr_len(op));
            for (int i = 0; i < instr_len(op); i++) begin
                checks++;
                if (obs_q[i] !== model(op, fn, z, i + 1)) begin
                    errors++;
                    $display("FAIL random n%0d op%h f%h z%0d c%0d got %h exp %h", n, op, fn, z,
                             i + 1, obs_q[i], model(op, fn, z, i + 1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_branch();
        test_addi_sw_jump();
        test_back_to_back();
        test_bad_funct();
        test_halt();
        test_sw_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 Operation  input  6  opcode, instruction bits [31:26], from datapath instruction register.
REQ-004 Funct  input  6  instruction bits [5:0].
REQ-005 ALU_zero  input  1  ALU result equals zero.
REQ-006 pc_reset / pc_load  output  1 each  PC register control.
REQ-007 instReg_reset / instReg_load  output  1 each  instruction register control.
REQ-008 a_reset / a_load / b_reset / b_load  output  1 each  A and B register control.
REQ-009 ALUout_reset / ALUout_load  output  1 each  ALUout register control.
REQ-010 mdr_load  output  1  memory data register load.
REQ-011 mem_write  output  1  memory write strobe.
REQ-012 iord  output  1  memory address select: 0 = PC, 1 = ALUout.
REQ-013 ALU_srcA  output  1  0 = PC, 1 = A.
REQ-014 ALU_srcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
REQ-015 ALU_select  output  3  001 add, 010 sub, 011 and, 110 xor; all other codes unused.
REQ-016 pc_source  output  2  00 = ALU result, 01 = ALUout, 10 = {PC[31:28], imm26, 2'b00}.
REQ-017 reg_write / reg_dst / mem_to_reg  output  1 each  register-file write enable, destination select (1 = rd), write-back data select (1 = MDR).
REQ-018 error  output  1  high while the FSM is in HALT.

Function
REQ-019 Multicycle Moore FSM; outputs are decoded from the state register only, except pc_load in BRANCH (REQ-028). Unlisted outputs are 0.
REQ-020 RESET_ST: all five *_reset outputs = 1. Next state: FETCH.
REQ-021 FETCH: iord=0, nothing loaded. Memory read data is valid one cycle later. Next state: FETCH_WAIT.
REQ-022 FETCH_WAIT: iord=0, instReg_load=1, ALU_srcA=0, ALU_srcB=01, ALU_select=001, pc_source=00, pc_load=1. Next state: DECODE.
REQ-023 DECODE: a_load=b_load=ALUout_load=1, ALU_srcA=0, ALU_srcB=11, ALU_select=001. Next state by Operation: 0x00 R_EXEC; 0x08 ADDI_EXEC; 0x23 or 0x2B MEM_ADDR; 0x04 or 0x05 BRANCH; 0x02 JUMP; any other value HALT.
REQ-024 R_EXEC: ALU_srcA=1, ALU_srcB=00, ALUout_load=1. ALU_select from Funct: 0x20 add, 0x22 sub, 0x24 and, 0x26 xor. Next state: R_WB. Any other Funct: ALU_select=000, next state HALT.
REQ-025 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state: FETCH.
REQ-026 ADDI_EXEC: ALU_srcA=1, ALU_srcB=10, add, ALUout_load=1. Next state: ADDI_WB (reg_write=1, reg_dst=0), then FETCH.
REQ-027 MEM_ADDR: ALU_srcA=1, ALU_srcB=10, add, ALUout_load=1. Next state: LW_READ if 0x23, SW_WRITE if 0x2B.
  - LW_READ: iord=1, then LW_WAIT.
  - LW_WAIT: iord=1, mdr_load=1, then LW_WB.
  - LW_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
  - SW_WRITE: iord=1, mem_write=1 for exactly one cycle, then FETCH.
REQ-028 BRANCH: ALU_srcA=1, ALU_srcB=00, sub, pc_source=01.
  - pc_load = ALU_zero if Operation=0x04; pc_load = ~ALU_zero if Operation=0x05.
  - Next state: FETCH.
REQ-029 JUMP: pc_source=10, pc_load=1. Next state: FETCH.
REQ-030 HALT: error=1, all loads and writes 0. The FSM stays in HALT until reset.
REQ-031 Instruction latency in cycles, counted from FETCH entry:
  - R-type and addi: 5.
  - lw: 7.
  - sw: 5.
  - beq/bne: 4.
  - j: 4.
REQ-032 Operation and Funct are sampled only in DECODE and R_EXEC. Changes in those inputs in any other state have no effect.

Reset
REQ-033 reset=1 at a rising edge forces RESET_ST on that edge from any state, including mid-instruction and HALT. An in-flight store is abandoned: mem_write=0 from that edge.
REQ-034 With reset held, the FSM remains in RESET_ST. FETCH follows on the first edge with reset=0.

Verification
REQ-035 Reset release, Operation=0x00, Funct=0x20 -> cycle 1 FETCH, cycle 2 instReg_load=pc_load=1, cycle 5 reg_write=1 with reg_dst=1, then FETCH.
REQ-036 Operation=0x23 -> mdr_load=1 exactly in cycle 6, reg_write=1 with mem_to_reg=1 in cycle 7, no mem_write in any cycle.
REQ-037 Operation=0x04 with ALU_zero=1, then ALU_zero=0 -> pc_load=1, pc_source=01 in cycle 4 for the first; pc_load=0 for the second. Repeat with 0x05 -> inverted results.
REQ-038 Operation=0x3F -> error=1 from cycle 4 onward, held 20 cycles; reset pulse -> error=0 and RESET_ST on that edge.
REQ-039 Operation=0x2B with reset asserted in the SW_WRITE cycle -> mem_write=0 after that edge, all *_reset=1, FETCH on the next edge.
REQ-040 R-type with Funct=0x08 -> HALT entered; reg_write never asserted.
